// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder interface: mode encodings,
// AB phase constants, transition decoding and signed saturation.
package quad_pkg;

  typedef enum logic [1:0] {
    QUAD_X4     = 2'b00,
    QUAD_X2     = 2'b01,
    QUAD_X1     = 2'b10,
    QUAD_X4_ALT = 2'b11
  } quad_mode_e;

  // Phase states {A,B} in forward (count-up) order: 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  typedef struct packed {
    logic illegal;  // both phases moved in one filtered sample
    logic up;       // direction implied by the transition
    logic counted;  // legal transition that the selected mode counts
  } quad_dec_t;

  function automatic quad_dec_t quad_decode(input logic [1:0]  prev,
                                            input logic [1:0]  now,
                                            input quad_mode_e  mode);
    quad_dec_t  d;
    logic [1:0] chg;
    logic       legal;
    chg       = prev ^ now;
    legal     = (chg == 2'b01) || (chg == 2'b10);
    d.illegal = (chg == 2'b11);
    d.up      = now[0] ^ prev[1];
    case (mode)
      QUAD_X2: d.counted = legal && (chg == 2'b10);
      QUAD_X1: d.counted = ((prev == AB_10) && (now == AB_00)) ||
                           ((prev == AB_00) && (now == AB_10));
      default: d.counted = legal;
    endcase
    return d;
  endfunction

  // Clamp to the range of a signed value of the given bit width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchroniser plus stability filter for one asynchronous encoder pin.
// level_o follows the synced level once it has held FILTER_LEN cycles.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic valid_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;   // marks stages holding a real pin sample
  logic                   synced;
  logic                   synced_ok;
  logic                   cand_q;
  logic                   cand_ok_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   valid_q;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign synced_ok = fill_q[SYNC_STAGES-1];

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the chain a chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      fill_q    <= '0;
      cand_q    <= 1'b0;
      cand_ok_q <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};

      if (!cand_ok_q || (synced != cand_q)) begin
        cand_q    <= synced;
        cand_ok_q <= synced_ok;
        cnt_q     <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // The candidate has been observed for FILTER_LEN cycles by now.
      if (cand_ok_q && (cnt_q == CNT_MAX)) begin
        level_q <= cand_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/quadrature_counter.sv
// Quadrature encoder front end: filtered A/B/I, x1/x2/x4 decoding, wrapping
// position count with load and index clear, sticky error, windowed velocity.
module quadrature_counter
  import quad_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int PERIOD      = 1000,
  parameter int VEL_WIDTH   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 A,
  input  logic                 B,
  input  logic                 I,
  input  logic [1:0]           mode,
  input  logic                 index_clr_en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     count,
  output logic                 dir,
  output logic                 step,
  output logic                 index_seen,
  output logic                 err,
  output logic [VEL_WIDTH-1:0] velocity,
  output logic                 vel_valid
);

  localparam int WIN_W = $clog2(PERIOD);
  localparam int ACC_W = $clog2(PERIOD) + 2;

  logic a_f, b_f, i_f;
  logic a_v, b_v, i_v;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .pin_i(A), .level_o(a_f), .valid_o(a_v)
  );
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .pin_i(B), .level_o(b_f), .valid_o(b_v)
  );
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clk(clk), .rst_n(rst_n), .pin_i(I), .level_o(i_f), .valid_o(i_v)
  );

  logic                        primed_q;
  logic [1:0]                  prev_q;
  logic                        i_prev_q;
  logic [WIDTH-1:0]            count_q, count_d;
  logic                        dir_q;
  logic                        step_q;
  logic                        index_seen_q;
  logic                        err_q;
  logic [WIN_W-1:0]            win_q, win_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [VEL_WIDTH-1:0]        velocity_q, velocity_d;
  logic                        vel_valid_q;

  logic                        all_valid;
  logic                        live;
  logic [1:0]                  ab_now;
  quad_dec_t                   dec;
  logic                        step_now;
  logic                        illegal_now;
  logic                        idx_rise;
  logic                        win_end;
  logic signed [31:0]          vel_sum;

  assign all_valid = a_v & b_v & i_v;
  assign ab_now    = {a_f, b_f};

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    live        = primed_q & all_valid;
    dec         = quad_decode(prev_q, ab_now, quad_mode_e'(mode));
    step_now    = live & dec.counted;
    illegal_now = live & dec.illegal;
    idx_rise    = live & i_f & ~i_prev_q;

    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (index_clr_en && idx_rise) begin
      count_d = '0;
    end else if (step_now) begin
      count_d = dec.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end

    // Velocity still sees steps that lost the count to load or index clear.
    vel_sum = {{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    if (step_now) vel_sum = dec.up ? vel_sum + 32'sd1 : vel_sum - 32'sd1;

    win_end    = (win_q == WIN_W'(PERIOD - 1));
    win_d      = win_end ? '0 : win_q + WIN_W'(1);
    acc_d      = win_end ? '0 : ACC_W'(vel_sum);
    velocity_d = VEL_WIDTH'(sat_signed(vel_sum, VEL_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      primed_q     <= 1'b0;
      prev_q       <= '0;
      i_prev_q     <= 1'b0;
      count_q      <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      index_seen_q <= 1'b0;
      err_q        <= 1'b0;
      win_q        <= '0;
      acc_q        <= '0;
      velocity_q   <= '0;
      vel_valid_q  <= 1'b0;
    end else begin
      // The first valid filtered sample only primes the history.
      if (all_valid) begin
        primed_q <= 1'b1;
        prev_q   <= ab_now;
        i_prev_q <= i_f;
      end

      count_q      <= count_d;
      step_q       <= step_now;
      index_seen_q <= idx_rise;
      if (step_now) dir_q <= dec.up;

      if (illegal_now)  err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;

      win_q       <= win_d;
      acc_q       <= acc_d;
      vel_valid_q <= win_end;
      if (win_end) velocity_q <= velocity_d;
    end
  end

  assign count      = count_q;
  assign dir        = dir_q;
  assign step       = step_q;
  assign index_seen = index_seen_q;
  assign err        = err_q;
  assign velocity   = velocity_q;
  assign vel_valid  = vel_valid_q;

endmodule
